// File: rtl/gearbox_pkg.sv
// gearbox_pkg
//   Shared helpers for the gearbox FIFO family (narrow-to-wide gearbox_fifo and
//   wide-to-narrow gearbox_fifo_w2n). It holds the default geometry and the
//   elaboration-time helpers that size the slice counter and the stored word.
package gearbox_pkg;

  // Default geometry of the egress gearbox.
  localparam int GB_IDATA_WIDTH_DEF = 64;
  localparam int GB_ODATA_WIDTH_DEF = 16;
  localparam int GB_DEPTH_DEF       = 16;
  localparam int GB_AE_LEVEL_DEF    = 4;
  localparam int GB_AF_LEVEL_DEF    = 4;

  // Integer ceiling division, used to count the slices that make up one word.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of narrow slices that cover one wide word.
  function automatic int slice_num(input int wide_w, input int narrow_w);
    return ceil_div(wide_w, narrow_w);
  endfunction

  // Width of a counter over n values. It is never narrower than one bit, so a
  // single-slice configuration still has a legal (constant-zero) register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gearbox_w2n_mem.sv
// gearbox_w2n_mem
//   Storage array for the wide-to-narrow gearbox. It is a simple dual-port RAM
//   with one synchronous write port and one asynchronous read port. The
//   asynchronous read gives first-word-fall-through behaviour. The array has
//   no reset, so its contents survive a FIFO reset.
// Ports
//   clk      in   1      clock
//   wr_en    in   1      write wr_data at wr_addr on the rising edge
//   wr_addr  in   AW     write address
//   wr_data  in   WIDTH  write data
//   rd_addr  in   AW     read address
//   rd_data  out  WIDTH  mem[rd_addr], combinational
module gearbox_w2n_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: the word is stored on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/gearbox_fifo_w2n.sv
// gearbox_fifo_w2n
//   Synchronous wide-to-narrow gearbox FIFO. Whole IDATA_WIDTH words are pushed
//   in. They come out as ODATA_WIDTH slices, least-significant slice first.
//   Full applies to whole words on push. Empty applies per slice on pop.
//   data_out is first-word-fall-through (combinational).
// Ports
//   clk               in   1            clock, rising edge
//   rst               in   1            synchronous reset, active-high
//   push_req_in       in   1            push one wide word
//   full_out          out  1            word count == DEPTH
//   almost_full_out   out  1            word count >= DEPTH-AF_LEVEL
//   data_in           in   IDATA_WIDTH  push data
//   pop_req_in        in   1            consume the current slice
//   empty_out         out  1            word count == 0
//   almost_empty_out  out  1            word count <= AE_LEVEL
//   data_out          out  ODATA_WIDTH  current slice, 0 while empty
//   error_out         out  1            sticky push-while-full / pop-while-empty
module gearbox_fifo_w2n
  import gearbox_pkg::*;
#(
  parameter int IDATA_WIDTH = GB_IDATA_WIDTH_DEF,
  parameter int ODATA_WIDTH = GB_ODATA_WIDTH_DEF,
  parameter int DEPTH       = GB_DEPTH_DEF,
  parameter int AE_LEVEL    = GB_AE_LEVEL_DEF,
  parameter int AF_LEVEL    = GB_AF_LEVEL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_req_in,
  output logic                   full_out,
  output logic                   almost_full_out,
  input  logic [IDATA_WIDTH-1:0] data_in,
  input  logic                   pop_req_in,
  output logic                   empty_out,
  output logic                   almost_empty_out,
  output logic [ODATA_WIDTH-1:0] data_out,
  output logic                   error_out
);

  localparam int SLICE_NUM = slice_num(IDATA_WIDTH, ODATA_WIDTH);
  localparam int SW        = SLICE_NUM * ODATA_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int SPW       = cnt_width(SLICE_NUM);
  localparam int AF_THR    = DEPTH - AF_LEVEL;

  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [SPW-1:0]         slice_pnt_r;
  logic                   error_r;
  logic [PW-1:0]          word_cnt_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_acc_s;
  logic                   pop_acc_s;
  logic                   retire_s;
  logic [SW-1:0]          wr_word_s;
  logic [SW-1:0]          rd_word_s;
  logic [ODATA_WIDTH-1:0] data_s;

  // The pointers carry a wrap bit, so their difference is the exact occupancy.
  assign word_cnt_s = wr_ptr_r - rd_ptr_r;
  assign full_s     = (word_cnt_s == PW'(DEPTH));
  assign empty_s    = (word_cnt_s == {PW{1'b0}});

  // Acceptance uses only the current-cycle flags. A pop that frees a word in
  // the same cycle does not let a push in, and a same-cycle push does not
  // feed a pop.
  assign push_acc_s = push_req_in & ~full_s;
  assign pop_acc_s  = pop_req_in & ~empty_s;
  assign retire_s   = pop_acc_s & (slice_pnt_r == SPW'(SLICE_NUM - 1));

  // A short final slice reads as zero because of this zero-extension.
  assign wr_word_s = SW'(data_in);

  gearbox_w2n_mem #(
    .WIDTH (SW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_acc_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data (wr_word_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_data (rd_word_s)
  );

  // Slice select: OR together the masked slices so only the slice at
  // slice_pnt survives. The output is forced to zero while empty.
  always_comb begin
    data_s = {ODATA_WIDTH{1'b0}};
    for (int i = 0; i < SLICE_NUM; i++) begin
      data_s = data_s | ({ODATA_WIDTH{(slice_pnt_r == SPW'(i)) & ~empty_s}}
                         & rd_word_s[i*ODATA_WIDTH +: ODATA_WIDTH]);
    end
  end

  // Pointer, slice counter and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      slice_pnt_r <= {SPW{1'b0}};
      error_r     <= 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (retire_s) begin
        slice_pnt_r <= {SPW{1'b0}};
        rd_ptr_r    <= rd_ptr_r + PW'(1);
      end else if (pop_acc_s) begin
        slice_pnt_r <= slice_pnt_r + SPW'(1);
      end
      error_r <= error_r | (push_req_in & full_s) | (pop_req_in & empty_s);
    end
  end

  assign full_out         = full_s;
  assign empty_out        = empty_s;
  assign almost_full_out  = (AF_THR <= 0) ? 1'b1 : (int'(word_cnt_s) >= AF_THR);
  assign almost_empty_out = (int'(word_cnt_s) <= AE_LEVEL);
  assign data_out         = data_s;
  assign error_out        = error_r;

endmodule

// File: tb/tb_gearbox_fifo_w2n.sv
// tb_gearbox_fifo_w2n
//   Directed bench for gearbox_fifo_w2n. The main instance is 64->16 with
//   DEPTH=4, AE_LEVEL=1, AF_LEVEL=1. A second instance is 40->16 and checks
//   the zero-padded short last slice. Expected values are written by hand.
module tb_gearbox_fifo_w2n;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic        pop;
  logic [63:0] din;
  logic        full;
  logic        afull;
  logic        empty;
  logic        aempty;
  logic [15:0] dout;
  logic        err;

  logic        push40;
  logic        pop40;
  logic [39:0] din40;
  logic        full40;
  logic        afull40;
  logic        empty40;
  logic        aempty40;
  logic [15:0] dout40;
  logic        err40;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gearbox_fifo_w2n #(
    .IDATA_WIDTH (64), .ODATA_WIDTH (16), .DEPTH (4), .AE_LEVEL (1), .AF_LEVEL (1)
  ) dut (
    .clk (clk), .rst (rst), .push_req_in (push), .full_out (full),
    .almost_full_out (afull), .data_in (din), .pop_req_in (pop),
    .empty_out (empty), .almost_empty_out (aempty), .data_out (dout),
    .error_out (err)
  );

  gearbox_fifo_w2n #(
    .IDATA_WIDTH (40), .ODATA_WIDTH (16), .DEPTH (4), .AE_LEVEL (1), .AF_LEVEL (1)
  ) dut40 (
    .clk (clk), .rst (rst), .push_req_in (push40), .full_out (full40),
    .almost_full_out (afull40), .data_in (din40), .pop_req_in (pop40),
    .empty_out (empty40), .almost_empty_out (aempty40), .data_out (dout40),
    .error_out (err40)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    push = 1'b1;
    din  = w;
    step();
    push = 1'b0;
  endtask

  // Pop all four slices of one word and check each slice, LS slice first.
  task automatic pop_word(input string tag, input logic [63:0] w);
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk(tag, {48'h0, dout}, {48'h0, w[i*16 +: 16]});
      step();
    end
    pop = 1'b0;
  endtask

  initial begin
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w2;
    logic [63:0] w3;
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = 64'h0;
    push40 = 1'b0; pop40 = 1'b0; din40 = 40'h0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_empty",  {63'h0, empty},  64'h1);
    chk("rst_aempty", {63'h0, aempty}, 64'h1);
    chk("rst_full",   {63'h0, full},   64'h0);
    chk("rst_afull",  {63'h0, afull},  64'h0);
    chk("rst_dout",   {48'h0, dout},   64'h0);
    chk("rst_err",    {63'h0, err},    64'h0);

    // 1: single word, four slices
    push_word(64'h4444_3333_2222_1111);
    chk("t1_empty",  {63'h0, empty},  64'h0);
    chk("t1_aempty", {63'h0, aempty}, 64'h1);
    pop_word("t1_slice", 64'h4444_3333_2222_1111);
    chk("t1_empty_after", {63'h0, empty}, 64'h1);
    chk("t1_dout_zero",   {48'h0, dout},  64'h0);

    // 2: fill, overflow, drain first two words
    w0 = 64'hA003_A002_A001_A000;
    w1 = 64'hB003_B002_B001_B000;
    w2 = 64'hC003_C002_C001_C000;
    w3 = 64'hD003_D002_D001_D000;
    push_word(w0);
    chk("t2_afull_1", {63'h0, afull}, 64'h0);
    push_word(w1);
    chk("t2_afull_2",  {63'h0, afull},  64'h0);
    chk("t2_aempty_2", {63'h0, aempty}, 64'h0);
    push_word(w2);
    chk("t2_afull_3", {63'h0, afull}, 64'h1);
    chk("t2_full_3",  {63'h0, full},  64'h0);
    push_word(w3);
    chk("t2_full_4", {63'h0, full}, 64'h1);
    chk("t2_err_4",  {63'h0, err},  64'h0);
    push_word(64'hEEEE_EEEE_EEEE_EEEE);
    chk("t2_err_ovf",  {63'h0, err},  64'h1);
    chk("t2_full_ovf", {63'h0, full}, 64'h1);
    pop_word("t2_w0", w0);
    pop_word("t2_w1", w1);
    chk("t2_next", {48'h0, dout}, 64'h0000_0000_0000_C000);
    do_reset();
    chk("t2_rst_err",   {63'h0, err},   64'h0);
    chk("t2_rst_empty", {63'h0, empty}, 64'h1);

    // 3: pop while empty
    pop = 1'b1;
    chk("t3_dout", {48'h0, dout}, 64'h0);
    step();
    pop = 1'b0;
    chk("t3_err",   {63'h0, err},   64'h1);
    chk("t3_empty", {63'h0, empty}, 64'h1);
    step();
    step();
    chk("t3_err_held", {63'h0, err}, 64'h1);
    push_word(64'h0F0F_0E0E_0D0D_0C0C);
    pop_word("t3_noptr", 64'h0F0F_0E0E_0D0D_0C0C);
    chk("t3_err_held2", {63'h0, err}, 64'h1);
    do_reset();
    chk("t3_err_clr", {63'h0, err}, 64'h0);

    // 4: full with a same-cycle pop. Retiring pop and non-retiring pop cases.
    w0 = 64'h1003_1002_1001_1000;
    w1 = 64'h2003_2002_2001_2000;
    w2 = 64'h3003_3002_3001_3000;
    w3 = 64'h4003_4002_4001_4000;
    push_word(w0); push_word(w1); push_word(w2); push_word(w3);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    chk("t4_full_pre", {63'h0, full}, 64'h1);
    chk("t4_slice3",   {48'h0, dout}, 64'h0000_0000_0000_1003);
    push = 1'b1;
    din  = 64'h9999_9999_9999_9999;
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("t4_err",      {63'h0, err},   64'h1);
    chk("t4_full_3",   {63'h0, full},  64'h0);
    chk("t4_afull_3",  {63'h0, afull}, 64'h1);
    chk("t4_head",     {48'h0, dout},  64'h0000_0000_0000_2000);
    push_word(64'h5003_5002_5001_5000);
    chk("t4_full_again", {63'h0, full}, 64'h1);
    push = 1'b1;
    pop  = 1'b1;
    din  = 64'h8888_8888_8888_8888;
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("t4_full_stay", {63'h0, full}, 64'h1);
    chk("t4_slice1",    {48'h0, dout}, 64'h0000_0000_0000_2001);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    pop = 1'b0;
    pop_word("t4_w2", w2);
    pop_word("t4_w3", w3);
    pop_word("t4_w5", 64'h5003_5002_5001_5000);
    chk("t4_empty", {63'h0, empty}, 64'h1);

    // 5: one word held, push in the same cycle as a retiring pop
    do_reset();
    push_word(64'h6003_6002_6001_6000);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    chk("t5_last", {48'h0, dout}, 64'h0000_0000_0000_6003);
    push = 1'b1;
    din  = 64'h7003_7002_7001_7000;
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("t5_empty",  {63'h0, empty},  64'h0);
    chk("t5_aempty", {63'h0, aempty}, 64'h1);
    chk("t5_afull",  {63'h0, afull},  64'h0);
    pop_word("t5_new", 64'h7003_7002_7001_7000);
    chk("t5_drained", {63'h0, empty}, 64'h1);

    // 6: reset in the middle of a word
    push_word(64'hAAAA_BBBB_CCCC_DDDD);
    push_word(64'h1111_2222_3333_4444);
    pop = 1'b1;
    step();
    step();
    pop = 1'b0;
    chk("t6_mid", {48'h0, dout}, 64'h0000_0000_0000_BBBB);
    do_reset();
    chk("t6_empty", {63'h0, empty}, 64'h1);
    chk("t6_dout",  {48'h0, dout},  64'h0);
    push_word(64'h0123_4567_89AB_CDEF);
    pop_word("t6_fresh", 64'h0123_4567_89AB_CDEF);

    // 7: 40->16, three slices, last slice zero-padded
    push40 = 1'b1;
    din40  = 40'h99_8877_6655;
    step();
    push40 = 1'b0;
    pop40  = 1'b1;
    chk("t7_s0", {48'h0, dout40}, 64'h0000_0000_0000_6655);
    step();
    chk("t7_s1", {48'h0, dout40}, 64'h0000_0000_0000_8877);
    step();
    chk("t7_s2", {48'h0, dout40}, 64'h0000_0000_0000_0099);
    step();
    pop40 = 1'b0;
    chk("t7_empty", {63'h0, empty40}, 64'h1);
    chk("t7_err",   {63'h0, err40},   64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
